// File: rtl/cache_pkg.sv
// Shared types and address helpers for the data-cache refill controller.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WRITE,
        DONE
    } state_t;

    localparam int LINE_WORDS  = 4;
    localparam int OFFSET_BITS = $clog2(LINE_WORDS);

    // Mask covering the byte offset plus word offset within one line.
    function automatic int offsetMask(input int offsetBits);
        return (1 << (offsetBits + 2)) - 1;
    endfunction

endpackage

// File: rtl/dcache_refill_fsm.sv
// Miss-refill and write-through sequencer for the direct-mapped data cache.
module dcache_refill_fsm #(
    parameter int LINE_WORDS = cache_pkg::LINE_WORDS,
    parameter int ADDR_W     = 32
) (
    input  logic                          iClk,
    input  logic                          iRst,
    input  logic                          iReq,
    input  logic                          iWriteEn,
    input  logic [ADDR_W-1:0]             iAddress,
    input  logic [31:0]                   iWriteData,
    input  logic                          iHit,
    output logic                          oStall,
    output logic                          oMemReq,
    output logic                          oMemWriteEn,
    output logic [ADDR_W-1:0]             oMemAddress,
    output logic [31:0]                   oMemWriteData,
    input  logic                          iMemReady,
    input  logic [31:0]                   iMemData,
    output logic                          oFillEn,
    output logic [$clog2(LINE_WORDS)-1:0] oFillIdx,
    output logic [31:0]                   oFillData,
    output logic                          oTagWrite,
    output logic                          oCacheWrite
);
    import cache_pkg::*;

    localparam int                OFF_W     = $clog2(LINE_WORDS);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(offsetMask(OFF_W));
    localparam logic [OFF_W-1:0]  LAST_IDX  = OFF_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

    state_t           state;
    logic [OFF_W-1:0] cnt;
    logic             hitLatched;
    logic             isMiss;
    logic             isStore;

    // Reset masks the combinational strobes so nothing leaks out while it is held.
    always_comb begin
        isMiss      = iReq & ~iWriteEn & ~iHit;
        isStore     = iReq & iWriteEn;
        oStall      = ~iRst & ((state == REFILL) | (state == WRITE) |
                               ((state == IDLE) & (isMiss | isStore)));
        oFillEn     = ~iRst & (state == REFILL) & iMemReady;
        oFillIdx    = cnt;
        oFillData   = iMemData;
        oTagWrite   = oFillEn & (cnt == LAST_IDX);
        oCacheWrite = ~iRst & (state == WRITE) & iMemReady & hitLatched;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state         <= IDLE;
            cnt           <= '0;
            hitLatched    <= 1'b0;
            oMemReq       <= 1'b0;
            oMemWriteEn   <= 1'b0;
            oMemAddress   <= '0;
            oMemWriteData <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (isMiss) begin
                        oMemAddress <= iAddress & LINE_MASK;
                        cnt         <= '0;
                        oMemReq     <= 1'b1;
                        oMemWriteEn <= 1'b0;
                        state       <= REFILL;
                    end else if (isStore) begin
                        oMemAddress   <= iAddress;
                        oMemWriteData <= iWriteData;
                        hitLatched    <= iHit;
                        oMemReq       <= 1'b1;
                        oMemWriteEn   <= 1'b1;
                        state         <= WRITE;
                    end
                end
                REFILL: begin
                    // Address and counter advance together so the address stays base + 4*cnt.
                    if (iMemReady) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_IDX) begin
                            oMemReq <= 1'b0;
                            state   <= DONE;
                        end else begin
                            oMemAddress <= oMemAddress + WORD_STEP;
                        end
                    end
                end
                WRITE: begin
                    if (iMemReady) begin
                        oMemReq     <= 1'b0;
                        oMemWriteEn <= 1'b0;
                        hitLatched  <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
